bus_fabric: RTL

Parametrised memory-mapped interconnect between the core's data port and N peripheral slaves; it replaces the fixed combinational decoder and read mux of the SoC top. It adds a registered request/ready handshake with per-slave wait states, a bus-timeout watchdog, and decode/timeout error reporting. It sits between the core data interface and the RAM, switch, LED and 7-segment peripherals; the core stalls on o_m_ready.

---
 rtl/bus_fabric.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - memory-mapped interconnect: address decode, wait-state handshake, timeout watchdog, error log
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_m_req/we/addr/wdata              master request, held until o_m_ready
//   o_m_rdata/ready/err                master response (o_m_ready is a one-cycle pulse, o_m_err qualifies it)
//   o_s_sel/we/addr/wdata              slave request (one-hot select, latched address/data)
//   i_s_rdata/ready                    per-slave read data (packed, slave k at [k*DATA_W +: DATA_W]) and ready
//   o_err_code/addr/cnt                sticky last-error code and address, saturating error count

module bus_fabric #(
    parameter int                NUM_SLAVES = 4,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                SEL_LSB    = 12,
    parameter int                SEL_W      = 2,
    parameter logic [ADDR_W-1:0] BASE       = '0,
    parameter int                TIMEOUT    = 15
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_m_req,
    input  logic                         i_m_we,
    input  logic [ADDR_W-1:0]            i_m_addr,
    input  logic [DATA_W-1:0]            i_m_wdata,
    output logic [DATA_W-1:0]            o_m_rdata,
    output logic                         o_m_ready,
    output logic                         o_m_err,
    output logic [NUM_SLAVES-1:0]        o_s_sel,
    output logic                         o_s_we,
    output logic [ADDR_W-1:0]            o_s_addr,
    output logic [DATA_W-1:0]            o_s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] i_s_rdata,
    input  logic [NUM_SLAVES-1:0]        i_s_ready,
    output logic [1:0]                   o_err_code,
    output logic [ADDR_W-1:0]            o_err_addr,
    output logic [7:0]                   o_err_cnt
);

    localparam int UP_LSB = SEL_LSB + SEL_W;
    // Counter only needs to reach TIMEOUT-1.
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [SEL_W-1:0]        idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    err_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [1:0]              err_code_q;
    logic [ADDR_W-1:0]       err_addr_q;
    logic [7:0]              err_cnt_q;

    logic [SEL_W-1:0]        req_idx;
    logic [31:0]             req_idx_ext;
    logic                    base_hit;
    logic                    idx_ok;

    logic [NUM_SLAVES-1:0]   sel_onehot;
    logic [DATA_W-1:0]       sel_rdata;
    logic                    sel_ready;

    logic                    latch;
    logic                    miss;
    logic                    done_ok;
    logic                    tmo;

    // Decode works on the live request; it only matters in the IDLE cycle that latches it.
    assign req_idx     = i_m_addr[SEL_LSB +: SEL_W];
    assign req_idx_ext = 32'(req_idx);
    assign base_hit    = (i_m_addr >> UP_LSB) == (BASE >> UP_LSB);
    assign idx_ok      = req_idx_ext < 32'(NUM_SLAVES);

    // Loop-based mux keeps out-of-range indices harmless when NUM_SLAVES < 2**SEL_W.
    always_comb begin
        sel_onehot = '0;
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SEL_W'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_rdata     = i_s_rdata[k*DATA_W +: DATA_W];
                sel_ready     = i_s_ready[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        miss    = 1'b0;
        done_ok = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_m_req) begin
                    latch = 1'b1;
                    if (base_hit && idx_ok) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = RESP;
                        miss    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked first so it wins over a coincident timeout.
                if (sel_ready) begin
                    state_d = RESP;
                    done_ok = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    tmo     = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            err_code_q <= 2'b00;
            err_addr_q <= '0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                we_q    <= i_m_we;
                addr_q  <= i_m_addr;
                wdata_q <= i_m_wdata;
                idx_q   <= req_idx;
                cnt_q   <= '0;
                err_q   <= miss;
            end
            if (state_q == ACCESS && !done_ok && !tmo) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done_ok) begin
                err_q <= 1'b0;
                if (!we_q) begin
                    rdata_q <= sel_rdata;
                end
            end
            if (tmo) begin
                err_q <= 1'b1;
            end
            if (miss || tmo) begin
                err_code_q <= miss ? 2'b01 : 2'b10;
                err_addr_q <= miss ? i_m_addr : addr_q;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign o_m_rdata  = rdata_q;
    assign o_m_ready  = (state_q == RESP);
    assign o_m_err    = (state_q == RESP) && err_q;
    assign o_s_sel    = (state_q == ACCESS) ? sel_onehot : '0;
    assign o_s_we     = (state_q == ACCESS) && we_q;
    assign o_s_addr   = addr_q;
    assign o_s_wdata  = wdata_q;
    assign o_err_code = err_code_q;
    assign o_err_addr = err_addr_q;
    assign o_err_cnt  = err_cnt_q;

endmodule
